// File: rtl/spi_burst_transactor_if.sv
// Host and SPI-side signals of the burst shift engine.
// slave: the engine; master: the sequencer / clock divider / line side.
interface spi_burst_transactor_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 4
);
  logic              spi_clk_rising;
  logic              spi_clk_falling;
  logic              start;
  logic              abort;
  logic [CNT_W-1:0]  num_words;
  logic [DATA_W-1:0] tx_data;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              done;
  logic              busy;
  logic              spi_mosi;
  logic              spi_miso;

  modport slave (
    input  spi_clk_rising, spi_clk_falling, start, abort, num_words, tx_data, spi_miso,
    output tx_ready, rx_data, rx_valid, done, busy, spi_mosi
  );

  modport master (
    output spi_clk_rising, spi_clk_falling, start, abort, num_words, tx_data, spi_miso,
    input  tx_ready, rx_data, rx_valid, done, busy, spi_mosi
  );
endinterface

// File: rtl/spi_burst_transactor.sv
// SPI shift engine: bursts of num_words+1 words of DATA_W bits, driven by
// external SCK edge strobes from the clock divider.
//
// state    | meaning
// ST_IDLE  | no burst; MOSI parked at IDLE_MOSI
// ST_SHIFT | shifting bits of the current word
// ST_GAP   | word done, next word loads on the next falling strobe
module spi_burst_transactor #(
  parameter int DATA_W    = 8,
  parameter int CNT_W     = 4,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_MOSI = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  spi_burst_transactor_if.slave bus
);

  localparam int BC_W = $clog2(DATA_W);
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_GAP
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  words_left_q, words_left_d;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic              first_q, first_d;
  logic              mosi_q, mosi_d;
  logic              rx_valid_q, rx_valid_d;
  logic              done_q, done_d;

  logic              load;
  logic [DATA_W-1:0] rx_word;
  logic [DATA_W-1:0] tx_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      words_left_q <= '0;
      tx_shift_q   <= '0;
      rx_shift_q   <= '0;
      rx_data_q    <= '0;
      bit_cnt_q    <= '0;
      first_q      <= 1'b0;
      mosi_q       <= IDLE_MOSI;
      rx_valid_q   <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      words_left_q <= words_left_d;
      tx_shift_q   <= tx_shift_d;
      rx_shift_q   <= rx_shift_d;
      rx_data_q    <= rx_data_d;
      bit_cnt_q    <= bit_cnt_d;
      first_q      <= first_d;
      mosi_q       <= mosi_d;
      rx_valid_q   <= rx_valid_d;
      done_q       <= done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    words_left_d = words_left_q;
    tx_shift_d   = tx_shift_q;
    rx_shift_d   = rx_shift_q;
    rx_data_d    = rx_data_q;
    bit_cnt_d    = bit_cnt_q;
    first_d      = first_q;
    mosi_d       = mosi_q;
    rx_valid_d   = 1'b0;
    done_d       = 1'b0;
    load         = 1'b0;

    rx_word = MSB_FIRST ? {rx_shift_q[DATA_W-2:0], bus.spi_miso}
                        : {bus.spi_miso, rx_shift_q[DATA_W-1:1]};
    tx_next = MSB_FIRST ? (tx_shift_q << 1) : (tx_shift_q >> 1);

    if (bus.abort) begin
      state_d = ST_IDLE;
      mosi_d  = IDLE_MOSI;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            load         = 1'b1;
            words_left_d = bus.num_words;
            state_d      = ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          // Rising wins when both strobes collide; the launch is dropped.
          if (bus.spi_clk_rising) begin
            rx_shift_d = rx_word;
            bit_cnt_d  = bit_cnt_q + 1'b1;
            first_d    = 1'b0;
            if (bit_cnt_q == LAST_BIT) begin
              rx_data_d  = rx_word;
              rx_valid_d = 1'b1;
              if (words_left_q == '0) begin
                done_d  = 1'b1;
                mosi_d  = IDLE_MOSI;
                state_d = ST_IDLE;
              end else begin
                words_left_d = words_left_q - 1'b1;
                state_d      = ST_GAP;
              end
            end
          end else if (bus.spi_clk_falling && !first_q) begin
            tx_shift_d = tx_next;
            mosi_d     = MSB_FIRST ? tx_next[DATA_W-1] : tx_next[0];
          end
        end
        ST_GAP: begin
          if (bus.spi_clk_falling && !bus.spi_clk_rising) begin
            load    = 1'b1;
            state_d = ST_SHIFT;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // The preloaded first bit must survive the falling strobe that precedes
    // the word's first sample edge, hence first_d.
    if (load) begin
      tx_shift_d = bus.tx_data;
      mosi_d     = MSB_FIRST ? bus.tx_data[DATA_W-1] : bus.tx_data[0];
      bit_cnt_d  = '0;
      first_d    = 1'b1;
    end
  end

  assign bus.tx_ready = load;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.done     = done_q;
  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.spi_mosi = mosi_q;

endmodule

// File: tb/tb_spi_burst_transactor.sv
// Scoreboard bench for spi_burst_transactor: 8-bit MSB-first, 8-bit LSB-first
// and 16-bit instances share the strobes; sel picks which one is driven.
module tb_spi_burst_transactor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rise, fall, start_r, abort_r, miso_r;
  logic [3:0]  nw_r;
  logic [15:0] tx_cur;
  logic [1:0]  sel;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;
  int rxv_cnt  = 0;

  logic [15:0] txw [4];
  logic [15:0] rxw [4];

  typedef struct {
    logic [15:0] data;
    logic        last;
  } exp_t;
  exp_t exp_q [$];

  always #5 clk = ~clk;

  spi_burst_transactor_if #(.DATA_W(8),  .CNT_W(4)) if8  ();
  spi_burst_transactor_if #(.DATA_W(8),  .CNT_W(4)) ifl  ();
  spi_burst_transactor_if #(.DATA_W(16), .CNT_W(4)) if16 ();

  assign if8.spi_clk_rising   = rise;
  assign if8.spi_clk_falling  = fall;
  assign if8.start            = start_r & (sel == 2'd0);
  assign if8.abort            = abort_r & (sel == 2'd0);
  assign if8.num_words        = nw_r;
  assign if8.tx_data          = tx_cur[7:0];
  assign if8.spi_miso         = miso_r;

  assign ifl.spi_clk_rising   = rise;
  assign ifl.spi_clk_falling  = fall;
  assign ifl.start            = start_r & (sel == 2'd1);
  assign ifl.abort            = abort_r & (sel == 2'd1);
  assign ifl.num_words        = nw_r;
  assign ifl.tx_data          = tx_cur[7:0];
  assign ifl.spi_miso         = miso_r;

  assign if16.spi_clk_rising  = rise;
  assign if16.spi_clk_falling = fall;
  assign if16.start           = start_r & (sel == 2'd2);
  assign if16.abort           = abort_r & (sel == 2'd2);
  assign if16.num_words       = nw_r;
  assign if16.tx_data         = tx_cur;
  assign if16.spi_miso        = miso_r;

  spi_burst_transactor #(.DATA_W(8), .CNT_W(4), .MSB_FIRST(1'b1), .IDLE_MOSI(1'b1)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .bus(if8));
  spi_burst_transactor #(.DATA_W(8), .CNT_W(4), .MSB_FIRST(1'b0), .IDLE_MOSI(1'b1)) u_dutl (
    .clk(clk), .rst_n(rst_n), .bus(ifl));
  spi_burst_transactor #(.DATA_W(16), .CNT_W(4), .MSB_FIRST(1'b1), .IDLE_MOSI(1'b1)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .bus(if16));

  logic [15:0] obs_rx_data;
  logic        obs_tx_ready, obs_rx_valid, obs_done, obs_busy, obs_mosi;

  always_comb begin
    obs_rx_data  = {8'h00, if8.rx_data};
    obs_tx_ready = if8.tx_ready;
    obs_rx_valid = if8.rx_valid;
    obs_done     = if8.done;
    obs_busy     = if8.busy;
    obs_mosi     = if8.spi_mosi;
    if (sel == 2'd1) begin
      obs_rx_data  = {8'h00, ifl.rx_data};
      obs_tx_ready = ifl.tx_ready;
      obs_rx_valid = ifl.rx_valid;
      obs_done     = ifl.done;
      obs_busy     = ifl.busy;
      obs_mosi     = ifl.spi_mosi;
    end else if (sel == 2'd2) begin
      obs_rx_data  = if16.rx_data;
      obs_tx_ready = if16.tx_ready;
      obs_rx_valid = if16.rx_valid;
      obs_done     = if16.done;
      obs_busy     = if16.busy;
      obs_mosi     = if16.spi_mosi;
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every rx_valid must match the oldest expected word.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1) begin
      if (obs_rx_valid === 1'b1) begin
        rxv_cnt++;
        if (exp_q.size() == 0) begin
          chk("rx_stray", 16'(obs_rx_valid), 16'd0);
        end else begin
          e = exp_q.pop_front();
          chk("rx_data", obs_rx_data, e.data);
          chk("done_flag", 16'(obs_done), 16'(e.last));
        end
      end else if (obs_done === 1'b1) begin
        chk("done_stray", 16'(obs_done), 16'd0);
      end
      if (obs_done === 1'b1) done_cnt++;
    end
  end

  task automatic shift_bits(input int n);
    for (int i = 0; i < n; i++) begin
      fall = 1'b1; @(posedge clk); #1 fall = 1'b0;
      rise = 1'b1; @(posedge clk); #1 rise = 1'b0;
    end
  endtask

  task automatic run_burst(input int s, input int nw, input int dw, input bit msb);
    logic [15:0] mask;
    int bp;
    bit exp_tr;
    mask     = (dw == 16) ? 16'hFFFF : 16'h00FF;
    sel      = 2'(s);
    nw_r     = 4'(nw);
    tx_cur   = txw[0];
    done_cnt = 0;
    rxv_cnt  = 0;
    start_r  = 1'b1;
    @(negedge clk);
    chk("tx_ready_start", 16'(obs_tx_ready), 16'd1);
    @(posedge clk); #1 start_r = 1'b0;
    tx_cur = txw[1];
    for (int w = 0; w <= nw; w++) begin
      for (int b = 0; b < dw; b++) begin
        bp     = msb ? (dw - 1 - b) : b;
        exp_tr = (b == 0) && (w > 0);
        fall   = 1'b1;
        @(negedge clk);
        chk("tx_ready", 16'(obs_tx_ready), 16'(exp_tr));
        chk("busy", 16'(obs_busy), 16'd1);
        @(posedge clk); #1 fall = 1'b0;
        if (exp_tr && w < 3) tx_cur = txw[w+1];
        miso_r = rxw[w][bp];
        if (b == dw - 1) exp_q.push_back('{data: rxw[w] & mask, last: (w == nw)});
        @(negedge clk);
        chk("mosi", 16'(obs_mosi), 16'(txw[w][bp]));
        rise = 1'b1;
        @(posedge clk); #1 rise = 1'b0;
      end
    end
    @(negedge clk);
    chk("mosi_idle", 16'(obs_mosi), 16'd1);
    chk("busy_end", 16'(obs_busy), 16'd0);
    @(negedge clk);
    chk("done_cnt", 16'(done_cnt), 16'd1);
    chk("rxv_cnt", 16'(rxv_cnt), 16'(nw + 1));
    chk("sb_empty", 16'(exp_q.size()), 16'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    rise = 0; fall = 0; start_r = 0; abort_r = 0; miso_r = 0;
    nw_r = 0; tx_cur = 0; sel = 0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_busy", 16'(obs_busy), 16'd0);
    chk("rst_mosi", 16'(obs_mosi), 16'd1);
    chk("rst_rx_data", obs_rx_data, 16'd0);
    chk("rst_rx_valid", 16'(obs_rx_valid), 16'd0);
    chk("rst_done", 16'(obs_done), 16'd0);
    @(posedge clk); #1;

    // single word, MSB first
    txw = '{16'h00A5, 16'h0, 16'h0, 16'h0};
    rxw = '{16'h003C, 16'h0, 16'h0, 16'h0};
    run_burst(0, 0, 8, 1'b1);

    // three-word gapless burst
    txw = '{16'h0001, 16'h0080, 16'h00FF, 16'h0};
    rxw = '{16'h0011, 16'h0022, 16'h0033, 16'h0};
    run_burst(0, 2, 8, 1'b1);

    // ignored start mid-burst, then abort after 4 bits
    sel = 0; nw_r = 4'd1; tx_cur = 16'h00A5; done_cnt = 0; rxv_cnt = 0;
    start_r = 1'b1; @(posedge clk); #1 start_r = 1'b0;
    shift_bits(4);
    start_r = 1'b1;
    @(negedge clk);
    chk("start_busy_txr", 16'(obs_tx_ready), 16'd0);
    chk("start_busy_busy", 16'(obs_busy), 16'd1);
    @(posedge clk); #1 start_r = 1'b0;
    abort_r = 1'b1; @(posedge clk); #1 abort_r = 1'b0;
    @(negedge clk);
    chk("abort_busy", 16'(obs_busy), 16'd0);
    chk("abort_mosi", 16'(obs_mosi), 16'd1);
    chk("abort_rx_data", obs_rx_data, 16'h0033);
    shift_bits(2);
    @(negedge clk);
    chk("abort_done_cnt", 16'(done_cnt), 16'd0);
    chk("abort_rxv_cnt", 16'(rxv_cnt), 16'd0);
    @(posedge clk); #1;

    // asynchronous reset mid-word
    nw_r = 4'd0; tx_cur = 16'h00A5;
    start_r = 1'b1; @(posedge clk); #1 start_r = 1'b0;
    shift_bits(3);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 16'(obs_busy), 16'd0);
    chk("arst_mosi", 16'(obs_mosi), 16'd1);
    chk("arst_rx_data", obs_rx_data, 16'd0);
    chk("arst_rx_valid", 16'(obs_rx_valid), 16'd0);
    chk("arst_done", 16'(obs_done), 16'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    txw = '{16'h00A5, 16'h0, 16'h0, 16'h0};
    rxw = '{16'h003C, 16'h0, 16'h0, 16'h0};
    run_burst(0, 0, 8, 1'b1);

    // LSB-first instance
    txw = '{16'h0001, 16'h0, 16'h0, 16'h0};
    rxw = '{16'h0096, 16'h0, 16'h0, 16'h0};
    run_burst(1, 0, 8, 1'b0);

    // 16-bit instance
    txw = '{16'hBEEF, 16'h0, 16'h0, 16'h0};
    rxw = '{16'h1234, 16'h0, 16'h0, 16'h0};
    run_burst(2, 0, 16, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
